alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined ALU; successor to the 4-bit combinational ALU.
//  Adds WIDTH generalisation, 8 ops, full flag set (C/Z/N/V) and valid/ready
//  handshakes on both sides so it can sit between buffered datapath stages.
//  Stage 1 registers operands/op; stage 2 registers result and flags.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      ALU can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   3      operation select
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result this cycle
//  out_res    out  WIDTH  result
//  out_c      out  1      carry (ADD) / borrow (SUB); 0 for other ops
//  out_z      out  1      out_res == 0
//  out_n      out  1      out_res[WIDTH-1]
//  out_v      out  1      signed overflow (ADD/SUB only; else 0)
// BEHAVIOUR
//  Reset: rst_n low asynchronously clears s1_valid, s2_valid, out_res, all flags;
//   out_valid=0. in_ready=1 during reset; beats presented during reset are dropped.
//  Ops: 000 ADD {c,res}=A+B | 001 SUB {c,res}=A-B, c=1 iff A<B unsigned
//   010 AND | 011 OR | 100 XOR | 101 SHL res=A<<B[$clog2(WIDTH)-1:0]
//   110 SHR logical, same shift amount | 111 SLTU res=(A<B unsigned)?1:0.
//   Shift amount uses low clog2(WIDTH) bits of B only; higher bits ignored.
//  V: ADD: A,B same sign and res sign differs; SUB: A,B signs differ and res
//   sign != A sign. Z/N computed from final WIDTH-bit result for all ops.
//  Handshake: transfer on in side when in_valid&in_ready; out side when
//   out_valid&out_ready. in_valid/in_a/in_b/in_op need not hold without ready.
//   out_res/flags/out_valid stable while out_valid&!out_ready.
//  Pipeline: s2 loads when !s2_valid || out_ready; s1 loads when
//   !s1_valid || s2 loads. in_ready = !s1_valid || s2_load (combinational
//   from out_ready; no comb path from in_valid to in_ready).
//  Latency: accepted beat appears on out_valid 2 cycles later when unstalled.
//   Throughput 1 beat/cycle with out_ready held high.
//  Stall: out_ready low holds s2; s1 fills; in_ready drops once s1 full.
//   Max 2 beats in flight; no beat lost or duplicated; order preserved.
//  Simultaneous: s2 drain and s1->s2 move and new in accept in same cycle OK.
//  Reset mid-operation: in-flight beats discarded, pipeline empty next cycle.
//  Arithmetic computed in stage 1->2 transfer; all outputs registered.
// TESTING (WIDTH=8)
//  ADD 8'hFF+8'h01 -> res 00, c=1,z=1,n=0,v=0, out_valid 2 cycles after accept
//  SUB 8'h80-8'h01 -> res 7F, c=0,v=1; SUB 8'h03-8'h05 -> res FE, c=1,n=1,v=0
//  SHL A=8'h81,B=8'h09 -> res 02 (shift 1); SLTU 3,5 -> 01; SLTU 5,3 -> 00,z=1
//  Stream 10 ops, out_ready low cycles 3-6: in_ready low after 2 buffered,
//   all 10 results emerge in order, held stable while stalled, none dropped
//  Back-to-back 16 beats with out_ready=1: one result per cycle, latency 2
//  rst_n low with 2 beats in flight -> out_valid=0 at once; no stale output

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 holds operands and op; stage 2 holds the registered result and C/Z/N/V flags.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  localparam int SW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB = WIDTH - 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_c;
  logic             nxt_v;

  // Stage 2 frees up when empty or draining; stage 1 frees up behind it.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Result and C/V from the stage-1 operands; Z/N derive from the result at load.
  always_comb begin
    sum_ext = {1'b0, s1_a} + {1'b0, s1_b};
    dif_ext = {1'b0, s1_a} - {1'b0, s1_b};
    nxt_res = {WIDTH{1'b0}};
    nxt_c   = 1'b0;
    nxt_v   = 1'b0;
    case (s1_op)
      3'b000: begin
        nxt_res = sum_ext[WIDTH-1:0];
        nxt_c   = sum_ext[WIDTH];
        nxt_v   = (s1_a[MSB] == s1_b[MSB]) && (sum_ext[MSB] != s1_a[MSB]);
      end
      3'b001: begin
        nxt_res = dif_ext[WIDTH-1:0];
        nxt_c   = dif_ext[WIDTH];
        nxt_v   = (s1_a[MSB] != s1_b[MSB]) && (dif_ext[MSB] != s1_a[MSB]);
      end
      3'b010:  nxt_res = s1_a & s1_b;
      3'b011:  nxt_res = s1_a | s1_b;
      3'b100:  nxt_res = s1_a ^ s1_b;
      3'b101:  nxt_res = s1_a << s1_b[SW-1:0];
      3'b110:  nxt_res = s1_a >> s1_b[SW-1:0];
      3'b111:  nxt_res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
      default: nxt_res = {WIDTH{1'b0}};
    endcase
  end

  // Stage 1: operand capture whenever the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= {WIDTH{1'b0}};
      s1_b     <= {WIDTH{1'b0}};
      s1_op    <= 3'b000;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // Stage 2: output registers, frozen while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_res  <= {WIDTH{1'b0}};
      out_c    <= 1'b0;
      out_z    <= 1'b0;
      out_n    <= 1'b0;
      out_v    <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_res <= nxt_res;
        out_c   <= nxt_c;
        out_z   <= (nxt_res == {WIDTH{1'b0}});
        out_n   <= nxt_res[MSB];
        out_v   <= nxt_v;
      end else begin
        out_res <= out_res;
      end
    end else begin
      s2_valid <= s2_valid;
    end
  end

endmodule
